// File: rtl/cbu_timer_ctrl.sv
// cbu_timer_ctrl -- cascadable up-counting timer controller.
// Counts from a loaded value up to all ones in 4-bit slices, then either reloads
// (periodic) or parks in DONE (one-shot). CAI/CAO allow chaining controllers.
// Optional feature: define CBU_TIMER_PRESCALE_EN to add a PRESCALE input and a
// 4-bit strobe divider that runs only in RUN.
module cbu_timer_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   STOP,
    input  logic                   MODE,
    input  logic [4*NIBBLES-1:0]   LOAD_VAL,
`ifdef CBU_TIMER_PRESCALE_EN
    input  logic [3:0]             PRESCALE,
`endif
    input  logic                   CAI,
    output logic [4*NIBBLES-1:0]   COUNT,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   TICK,
    output logic                   CAO
);

    localparam int W = 4 * NIBBLES;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t         state;
    logic [W-1:0]   count_q;
    logic [W-1:0]   reload_q;
    logic           mode_q;
    logic           tick_q;
    logic           busy_q;
    logic           done_q;
    logic           stb;
    logic           tc;

    // Ripple a +1 through the 4-bit slices so each slice sees the carry of the one below.
    function automatic logic [W-1:0] inc_slices(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         c;
        logic [4:0]   s;
        r = '0;
        c = 1'b1;
        for (int n = 0; n < NIBBLES; n++) begin
            s              = {1'b0, v[4*n +: 4]} + {4'b0000, c};
            r[4*n +: 4]    = s[3:0];
            c              = s[4];
        end
        return r;
    endfunction

`ifdef CBU_TIMER_PRESCALE_EN
    logic [3:0] prescale_q;
    logic [3:0] div_q;

    // Strobe divider: advances on CAI in RUN, wraps at PRESCALE, cleared by START/STOP.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_q      <= 4'd0;
            prescale_q <= 4'd0;
        end else begin
            if (STOP || START)
                div_q <= 4'd0;
            else if (state == S_RUN && CAI)
                div_q <= (div_q == prescale_q) ? 4'd0 : div_q + 4'd1;
            if (START && !STOP)
                prescale_q <= PRESCALE;
        end
    end

    assign stb = CAI && (div_q == prescale_q);
`else
    assign stb = CAI;
`endif

    assign tc    = (state == S_RUN) && stb && (count_q == {W{1'b1}});
    assign CAO   = tc;
    assign COUNT = count_q;
    assign BUSY  = busy_q;
    assign DONE  = done_q;
    assign TICK  = tick_q;

    // Control FSM with counter datapath; STOP beats START beats terminal count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= 1'b0;
            tick_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            case (state)
                S_IDLE, S_RUN, S_DONE: begin
                    if (STOP) begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b0;
                    end else if (START) begin
                        count_q  <= LOAD_VAL;
                        reload_q <= LOAD_VAL;
                        mode_q   <= MODE;
                        state    <= S_RUN;
                        busy_q   <= 1'b1;
                        done_q   <= 1'b0;
                    end else if (state == S_RUN) begin
                        if (tc) begin
                            tick_q <= 1'b1;
                            if (mode_q) begin
                                count_q <= reload_q;
                            end else begin
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end
                        end else if (stb) begin
                            count_q <= inc_slices(count_q);
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cbu_timer_ctrl.sv
// Testbench for cbu_timer_ctrl (NIBBLES=4): directed vector table, a one-shot
// sequence, randomized traffic against a behavioural model, and a prescaler
// sequence when CBU_TIMER_PRESCALE_EN is defined.
module tb_cbu_timer_ctrl;

    localparam int W = 16;
    localparam logic [W-1:0] MAXV = 16'hFFFF;

    logic          CLK = 1'b0;
    logic          RST, START, STOP, MODE, CAI;
    logic [W-1:0]  LOAD_VAL;
    logic [W-1:0]  COUNT;
    logic          BUSY, DONE, TICK, CAO;
`ifdef CBU_TIMER_PRESCALE_EN
    logic [3:0]    PRESCALE;
`endif

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    cbu_timer_ctrl #(.NIBBLES(4)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .STOP     (STOP),
        .MODE     (MODE),
        .LOAD_VAL (LOAD_VAL),
`ifdef CBU_TIMER_PRESCALE_EN
        .PRESCALE (PRESCALE),
`endif
        .CAI      (CAI),
        .COUNT    (COUNT),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .TICK     (TICK),
        .CAO      (CAO)
    );

    typedef struct {
        logic         rst, start, stop, mode;
        logic [W-1:0] load;
        logic         cai;
        logic [W-1:0] e_cnt;
        logic         e_busy, e_done, e_tick, e_cao;
    } vec_t;

    vec_t tbl[$];

    // Behavioural reference: a running/expired flag pair plus plain integer counting.
    logic         m_running, m_expired, m_periodic, m_tick;
    int unsigned  m_cnt, m_reload;

    function automatic vec_t mk(input logic r, s, p, m, input logic [W-1:0] ld, input logic c,
                                input logic [W-1:0] ec, input logic eb, ed, et, eo);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.mode = m; v.load = ld; v.cai = c;
        v.e_cnt = ec; v.e_busy = eb; v.e_done = ed; v.e_tick = et; v.e_cao = eo;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic model_tc(input logic cai);
        return m_running && cai && (m_cnt == 32'hFFFF);
    endfunction

    task automatic model_update(input vec_t v);
        logic expire;
        expire = model_tc(v.cai);
        m_tick = 1'b0;
        if (v.rst) begin
            m_running = 0; m_expired = 0; m_periodic = 0; m_cnt = 0; m_reload = 0;
        end else if (v.stop) begin
            m_running = 0; m_expired = 0;
        end else if (v.start) begin
            m_cnt = v.load; m_reload = v.load; m_periodic = v.mode;
            m_running = 1; m_expired = 0;
        end else if (expire) begin
            m_tick = 1'b1;
            if (m_periodic) m_cnt = m_reload;
            else begin m_running = 0; m_expired = 1; end
        end else if (m_running && v.cai) begin
            m_cnt = (m_cnt + 1) % 65536;
        end
    endtask

    // One clock: drive inputs, check CAO before the edge, check registered outputs after it.
    task automatic run_cycle(input vec_t v, input bit use_model, input string tag);
        RST = v.rst; START = v.start; STOP = v.stop; MODE = v.mode;
        LOAD_VAL = v.load; CAI = v.cai;
        #1;
        if (use_model) check({tag, " cao"}, {31'b0, CAO}, {31'b0, model_tc(v.cai)});
        else           check({tag, " cao"}, {31'b0, CAO}, {31'b0, v.e_cao});
        @(posedge CLK);
        model_update(v);
        #1;
        if (use_model) begin
            check({tag, " count"}, {16'b0, COUNT}, m_cnt);
            check({tag, " busy"},  {31'b0, BUSY},  {31'b0, m_running});
            check({tag, " done"},  {31'b0, DONE},  {31'b0, m_expired});
            check({tag, " tick"},  {31'b0, TICK},  {31'b0, m_tick});
        end else begin
            check({tag, " count"}, {16'b0, COUNT}, {16'b0, v.e_cnt});
            check({tag, " busy"},  {31'b0, BUSY},  {31'b0, v.e_busy});
            check({tag, " done"},  {31'b0, DONE},  {31'b0, v.e_done});
            check({tag, " tick"},  {31'b0, TICK},  {31'b0, v.e_tick});
        end
    endtask

    initial begin
        vec_t v;
        int   ticks;

        //                 rst start stop mode load      cai  count     busy done tick cao
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 16'hFFFC, 1, 16'hFFFC, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFD, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFD, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFE, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFC, 1, 0, 1, 1));
        tbl.push_back(mk(0, 1, 1, 0, 16'h0000, 1, 16'hFFFC, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 16'hFFFE, 1, 16'hFFFE, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 16'hFFFE, 0, 16'hFFFE, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'hFFFE, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'hFFFE, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 16'h000F, 1, 16'h000F, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0010, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0010, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h0011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0011, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 16'h1230, 1, 16'h1230, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1231, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1232, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1233, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'h1234, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 0, 1, 16'hFFFF, 1, 16'h0000, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 16'hFFFF, 0, 16'hFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 16'h0005, 1, 16'h0005, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 0, 16'h0005, 1, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 16'hFFFF, 0, 16'hFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 1, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 16'h0000, 1, 16'hFFFF, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 16'hFFFF, 1, 16'hFFFF, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 1));

        RST = 1'b1; START = 1'b0; STOP = 1'b0; MODE = 1'b0; LOAD_VAL = '0; CAI = 1'b0;
`ifdef CBU_TIMER_PRESCALE_EN
        PRESCALE = 4'd0;
`endif
        m_running = 0; m_expired = 0; m_periodic = 0; m_tick = 0; m_cnt = 0; m_reload = 0;
        @(posedge CLK);
        @(posedge CLK);
        #1;

        for (int i = 0; i < tbl.size(); i++)
            run_cycle(tbl[i], 1'b0, $sformatf("row%0d", i));

        // One-shot from all ones: exactly one TICK, then DONE persists.
        ticks = 0;
        v = mk(0, 1, 0, 0, MAXV, 1, '0, 0, 0, 0, 0);
        run_cycle(v, 1'b1, "os_start");
        v.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            run_cycle(v, 1'b1, $sformatf("os%0d", i));
            if (TICK) ticks++;
        end
        check("os tick total", ticks, 1);
        check("os done held", {31'b0, DONE}, 1);

        // Randomized traffic against the model; loads biased toward the top to hit terminal counts.
        for (int i = 0; i < 3000; i++) begin
            v.rst   = ($urandom_range(0, 127) == 0);
            v.start = ($urandom_range(0, 15) == 0);
            v.stop  = ($urandom_range(0, 31) == 0);
            v.mode  = $urandom_range(0, 1);
            v.load  = ($urandom_range(0, 1) == 0) ? MAXV - 16'($urandom_range(0, 7))
                                                  : 16'($urandom_range(0, 65535));
            v.cai   = ($urandom_range(0, 3) != 0);
            run_cycle(v, 1'b1, $sformatf("rnd%0d", i));
        end

`ifdef CBU_TIMER_PRESCALE_EN
        // Prescale 2, periodic from FFFE: a step every 3 cycles, a TICK every 6.
        PRESCALE = 4'd2;
        RST = 1'b0; STOP = 1'b0; START = 1'b1; MODE = 1'b1; LOAD_VAL = 16'hFFFE; CAI = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("ps start count", {16'b0, COUNT}, 32'hFFFE);
        for (int k = 1; k <= 12; k++) begin
            @(posedge CLK);
            #1;
            check($sformatf("ps%0d count", k), {16'b0, COUNT},
                  ((k % 6) >= 3) ? 32'hFFFF : 32'hFFFE);
            check($sformatf("ps%0d tick", k), {31'b0, TICK}, (k % 6 == 0) ? 1 : 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cbu_timer_ctrl.md
CBU_TIMER_CTRL -- requirements
Module: cbu_timer_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of cascaded 4-bit count slices; count width W = 4*NIBBLES.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 START  input  1  start/restart request, sampled each edge.
REQ-005 STOP  input  1  stop request, sampled each edge.
REQ-006 MODE  input  1  0 = one-shot, 1 = periodic; latched on accepted START.
REQ-007 LOAD_VAL  input  W  start/reload value; latched on accepted START.
REQ-008 CAI  input  1  carry-in count enable from upstream stage; tie high when standalone.
REQ-009 COUNT  output  W  current counter value, registered.
REQ-010 BUSY  output  1  high in RUN state.
REQ-011 DONE  output  1  high in DONE state (one-shot expired).
REQ-012 TICK  output  1  registered one-cycle pulse, one cycle after each terminal count.
REQ-013 CAO  output  1  combinational carry-out = terminal-count strobe, for cascading a downstream controller.

Function
REQ-014 States: IDLE, RUN, DONE; 2-bit encoded; unused encodings go to IDLE on the next edge.
REQ-015 Count strobe STB = CAI (AND the prescaler strobe when REQ-030 applies).
REQ-016 Terminal TC = (state==RUN) && STB && (COUNT == all ones); CAO = TC, same cycle, no register.
REQ-017 IDLE: START=1 -> COUNT<=LOAD_VAL, RELOAD<=LOAD_VAL, MODE latched, state<=RUN; otherwise COUNT holds.
REQ-018 RUN, STB=1, not TC: COUNT<=COUNT+1, modulo 2^W, with full carry across all slices.
REQ-019 RUN, STB=0: COUNT and state hold.
REQ-020 RUN, TC, periodic: COUNT<=RELOAD, stay RUN; TICK=1 in the following cycle.
REQ-021 RUN, TC, one-shot: COUNT holds all ones, state<=DONE; TICK=1 in the following cycle.
REQ-022 Period in strobes = 2^W - RELOAD; RELOAD = all ones gives TC on every strobe.
REQ-023 DONE: START -> reload LOAD_VAL, state<=RUN; STOP -> IDLE, COUNT holds; otherwise hold.
REQ-024 RUN, START=1 (STOP=0): restart -- COUNT<=LOAD_VAL, relatch RELOAD/MODE, stay RUN; no TICK even if TC that cycle.
REQ-025 STOP has priority over START and over TC in any state: state<=IDLE, COUNT freezes, no TICK.
REQ-026 TICK is high for exactly one cycle per TC; back-to-back TCs give a TICK on consecutive cycles.

Reset
REQ-027 RST=1 at an edge: state<=IDLE, COUNT<=0, RELOAD<=0, MODE<=0, TICK<=0; BUSY=DONE=0 next cycle.
REQ-028 RST has priority over START, STOP and TC, including mid-RUN; CAO=0 while state is IDLE.

Configuration
REQ-029 Macro CBU_TIMER_PRESCALE_EN selects the prescaler feature.
REQ-030 Defined: add input PRESCALE[3:0], latched on accepted START; a 4-bit divider counts in RUN only; STB = CAI && (div==PRESCALE); div clears on START, STOP, RST and when it reaches PRESCALE with CAI=1; div holds while CAI=0.
REQ-031 Undefined: no PRESCALE port, no divider logic; STB = CAI.

Verification (NIBBLES=4, no prescale unless stated)
REQ-032 Periodic, LOAD_VAL=16'hFFFC, CAI=1, START 1 cycle -> COUNT FFFC,FFFD,FFFE,FFFF,FFFC...; CAO high in the FFFF cycle; TICK every 4th cycle.
REQ-033 One-shot, LOAD_VAL=16'hFFFE -> 2 cycles in RUN, then DONE=1, BUSY=0, COUNT=FFFF, one TICK; START again -> RUN from FFFE.
REQ-034 CAI toggled 1,0,1,0 from 16'h000F -> COUNT advances only on CAI=1 cycles; nibble carry gives 0010.
REQ-035 START and STOP together in RUN -> IDLE with COUNT frozen; RST mid-RUN at COUNT=1234 -> COUNT=0, IDLE, TICK=0.
REQ-036 With CBU_TIMER_PRESCALE_EN, PRESCALE=2, periodic, LOAD_VAL=16'hFFFE -> COUNT steps every 3 cycles; TICK every 6 cycles.
